// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: three single-entry result buffers (ALU0, ALU1, LSU)
// compete for two registered broadcast slots under a round-robin pointer.
module cdb_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [2:0]  req_valid,
  input  logic [47:0] req_data,
  input  logic [14:0] req_tag,
  output logic [2:0]  req_ready,
  output logic        cdb_valid_0,
  output logic [15:0] cdb_data_0,
  output logic [4:0]  cdb_tag_0,
  output logic        cdb_valid_1,
  output logic [15:0] cdb_data_1,
  output logic [4:0]  cdb_tag_1,
  output logic [15:0] conflict_cnt
);

  // Holding buffers, one per requester
  logic [2:0]  occupied;
  logic [15:0] buf_data [3];
  logic [4:0]  buf_tag  [3];

  // Round-robin pointer, always in {0,1,2}
  logic [1:0]  ptr;

  // Arbitration results
  logic        grant_a_vld;
  logic        grant_b_vld;
  logic [1:0]  grant_a;
  logic [1:0]  grant_b;
  logic [2:0]  granted;
  logic [1:0]  scan_idx;

  // Modulo-3 increment of a requester index
  function automatic logic [1:0] next_idx(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  // Scan ptr, ptr+1, ptr+2 and pick the first two occupied buffers
  always_comb begin
    grant_a_vld = 1'b0;
    grant_b_vld = 1'b0;
    grant_a     = ptr;
    grant_b     = ptr;
    scan_idx    = ptr;
    for (int j = 0; j < 3; j++) begin
      if (occupied[scan_idx]) begin
        if (!grant_a_vld) begin
          grant_a_vld = 1'b1;
          grant_a     = scan_idx;
        end else if (!grant_b_vld) begin
          grant_b_vld = 1'b1;
          grant_b     = scan_idx;
        end
      end
      scan_idx = next_idx(scan_idx);
    end
  end

  // Per-requester grant mask derived from the two grant indices
  always_comb begin
    granted = 3'b000;
    for (int k = 0; k < 3; k++) begin
      granted[k] = (grant_a_vld && (grant_a == 2'(k))) ||
                   (grant_b_vld && (grant_b == 2'(k)));
    end
  end

  // A buffer can accept when empty or when it drains this cycle; flush blocks all
  assign req_ready = {3{~flush}} & (~occupied | granted);

  // Holding buffers: load on handshake (refill wins over drain), clear on grant
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occupied <= 3'b000;
      for (int k = 0; k < 3; k++) begin
        buf_data[k] <= 16'h0000;
        buf_tag[k]  <= 5'd0;
      end
    end else if (flush) begin
      occupied <= 3'b000;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (req_valid[k] && req_ready[k]) begin
          occupied[k] <= 1'b1;
          buf_data[k] <= req_data[16*k +: 16];
          buf_tag[k]  <= req_tag[5*k +: 5];
        end else if (granted[k]) begin
          occupied[k] <= 1'b0;
        end
      end
    end
  end

  // Broadcast slots: grant A feeds slot 0, grant B slot 1; idle slots keep payload
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cdb_valid_0 <= 1'b0;
      cdb_data_0  <= 16'h0000;
      cdb_tag_0   <= 5'd0;
      cdb_valid_1 <= 1'b0;
      cdb_data_1  <= 16'h0000;
      cdb_tag_1   <= 5'd0;
    end else if (flush) begin
      cdb_valid_0 <= 1'b0;
      cdb_valid_1 <= 1'b0;
    end else begin
      cdb_valid_0 <= grant_a_vld;
      cdb_valid_1 <= grant_b_vld;
      if (grant_a_vld) begin
        cdb_data_0 <= buf_data[grant_a];
        cdb_tag_0  <= buf_tag[grant_a];
      end
      if (grant_b_vld) begin
        cdb_data_1 <= buf_data[grant_b];
        cdb_tag_1  <= buf_tag[grant_b];
      end
    end
  end

  // Pointer moves just past the last granted index, holds when nothing granted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= 2'd0;
    end else if (flush) begin
      ptr <= 2'd0;
    end else if (grant_b_vld) begin
      ptr <= next_idx(grant_b);
    end else if (grant_a_vld) begin
      ptr <= next_idx(grant_a);
    end
  end

  // Saturating count of cycles where every buffer is waiting; only reset clears it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      conflict_cnt <= 16'h0000;
    end else if ((occupied == 3'b111) && (conflict_cnt != 16'hFFFF)) begin
      conflict_cnt <= conflict_cnt + 16'h0001;
    end
  end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 The block SHALL have a single clock and an asynchronous, active-low reset.
REQ-002 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst, input, 1 bit: asynchronous active-low reset; rst=0 SHALL clear all state immediately, independent of clk.
REQ-004 Port flush, input, 1 bit: synchronous pipeline flush, active-high.
REQ-005 Port req_valid, input, 3 bits: per-requester result valid; bit0=ALU0, bit1=ALU1, bit2=LSU.
REQ-006 Port req_data, input, 48 bits: packed 16-bit results; requester k uses bits [16k+15:16k].
REQ-007 Port req_tag, input, 15 bits: packed 5-bit RRF tags; requester k uses bits [5k+4:5k].
REQ-008 Port req_ready, output, 3 bits: per-requester accept; combinational.
REQ-009 Ports cdb_valid_0 / cdb_valid_1, output, 1 bit each: broadcast slot valid; registered.
REQ-010 Ports cdb_data_0 / cdb_data_1, output, 16 bits each: broadcast data; registered.
REQ-011 Ports cdb_tag_0 / cdb_tag_1, output, 5 bits each: broadcast RRF tag; registered.
REQ-012 Port conflict_cnt, output, 16 bits: saturating count of cycles in which all 3 holding buffers are occupied.

Function
REQ-013 Each requester SHALL own a one-entry holding buffer of {data, tag, occupied}.
REQ-014 req_ready[k] SHALL equal !flush && (!occupied[k] || granted[k]).
REQ-015 Handshake: req_valid[k] && req_ready[k] at a rising edge SHALL load buffer k and set occupied[k]; req_data and req_tag SHALL be ignored when req_valid[k]=0.
REQ-016 Grant and refill in the same cycle SHALL reload the buffer, sustaining 1 result/cycle/requester.
REQ-017 A granted buffer with no refill SHALL clear occupied[k] at the next edge.
REQ-018 Arbitration SHALL be combinational over the occupied buffers, with at most 2 grants per cycle and round-robin pointer ptr in {0,1,2}.
REQ-019 Grant A SHALL be the first occupied index scanning ptr, ptr+1, ptr+2 (mod 3); grant B SHALL be the next occupied index after A in the same scan order.
REQ-020 Grant A SHALL drive slot 0 and grant B SHALL drive slot 1; slot 1 SHALL never be valid while slot 0 is invalid.
REQ-021 At each edge, cdb_*_0 and cdb_*_1 SHALL load the granted buffer contents; an unused slot SHALL load valid=0 with data and tag held.
REQ-022 Latency: a result accepted at edge E into an empty, uncontended buffer SHALL appear on the CDB after edge E+1.
REQ-023 ptr SHALL update to (last granted index + 1) mod 3 and SHALL hold when there are no grants.
REQ-024 Fairness: with ptr advancing past each granted index, an occupied buffer SHALL be granted within 2 cycles.
REQ-025 conflict_cnt SHALL increment when occupied==3'b111, SHALL saturate at 16'hFFFF, and SHALL clear only on reset.
REQ-026 flush=1 at an edge SHALL clear all occupied bits, load cdb_valid_0 and cdb_valid_1 with 0, and set ptr to 0; requests in that cycle are not accepted because ready=0.
REQ-027 flush SHALL take precedence over grant and accept in the same cycle.

Reset
REQ-028 rst=0 SHALL force occupied=0, ptr=0, cdb_valid_*=0, cdb_data_*=0, cdb_tag_*=0, and conflict_cnt=0.
REQ-029 Reset asserted mid-operation SHALL drop in-flight results with no partial broadcast.
REQ-030 req_ready SHALL be 3'b111 during reset, since it is derived from the cleared state, but no accept SHALL occur until rst=1.

Verification
REQ-031 Single: ALU0 valid with data 16'h1234, tag 5'd7 for one cycle -> one edge later cdb_valid_0=1, data 16'h1234, tag 7; cdb_valid_1=0.
REQ-032 Triple: all 3 requesters valid simultaneously with ptr=0 -> slot0=ALU0, slot1=ALU1, LSU waits; next cycle slot0=LSU and ptr=0 afterward; conflict_cnt=1.
REQ-033 Back-pressure: all 3 requesters valid continuously for 6 cycles -> each requester granted 4 times in 6 cycles, with no requester idle for more than 2 cycles.
REQ-034 Flush: buffers full and flush pulsed -> next edge cdb_valid_*=0, req_ready=0 during the flush cycle, and no stale tag is ever broadcast.
REQ-035 Async reset: rst dropped mid-cycle -> outputs clear before the next clk edge, and conflict_cnt=0.
REQ-036 Saturation: 65540 cycles with all 3 buffers occupied -> conflict_cnt=16'hFFFF.
